// File: rtl/serial_mem_loader.sv
// Serial command loader: parses a UART byte stream and issues 32-bit
// word reads/writes on the memory-controller CPU port.
module serial_mem_loader #(
  parameter int ASIZE   = 20,
  parameter int DSIZE   = 32,
  parameter int TIMEOUT = 5000000
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             ext_cs_b,
  output logic             rnw,
  output logic [ASIZE-1:0] addr,
  output logic [DSIZE-1:0] dout,
  input  logic [DSIZE-1:0] din,
  input  logic             clken,
  output logic             busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, HDR, WFILL, WBUS, RBUS, RSEND, ACK, ERR
  } state_t;

  state_t           state_q;
  logic             wr_q;
  logic             en_q;
  logic [2:0]       bc_q;
  logic [15:0]      cnt_q;
  logic [31:0]      hdr_q;
  logic [ASIZE-1:0] addr_q;
  logic [DSIZE-1:0] dout_q;
  logic [DSIZE-1:0] rd_q;
  logic [7:0]       txd_q;
  logic             txv_q;
  logic             csb_q;
  logic             rnw_q;
  logic [TW-1:0]    to_q;

  logic        rx_fire;
  logic        tx_fire;
  logic [39:0] hdr_w;
  logic        unused_hdr;

  assign rx_ready = en_q & ((state_q == IDLE) |
                            (state_q == HDR)  |
                            (state_q == WFILL));
  assign busy     = (state_q != IDLE);
  assign tx_data  = txd_q;
  assign tx_valid = txv_q;
  assign ext_cs_b = csb_q;
  assign rnw      = rnw_q;
  assign addr     = addr_q;
  assign dout     = dout_q;

  assign rx_fire    = rx_valid & rx_ready;
  assign tx_fire    = txv_q & tx_ready;
  assign hdr_w      = {hdr_q, rx_data};
  assign unused_hdr = ^hdr_w;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      en_q    <= 1'b0;
      bc_q    <= '0;
      cnt_q   <= '0;
      hdr_q   <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      rd_q    <= '0;
      txd_q   <= '0;
      txv_q   <= 1'b0;
      csb_q   <= 1'b1;
      rnw_q   <= 1'b1;
      to_q    <= '0;
    end else begin
      en_q <= 1'b1;
      case (state_q)
        IDLE: begin
          to_q <= '0;
          if (rx_fire) begin
            if (rx_data == 8'h57 || rx_data == 8'h52) begin
              wr_q    <= (rx_data == 8'h57);
              bc_q    <= '0;
              state_q <= HDR;
            end else begin
              txd_q   <= 8'h3F;
              txv_q   <= 1'b1;
              state_q <= ERR;
            end
          end
        end
        HDR: begin
          if (rx_fire) begin
            to_q  <= '0;
            hdr_q <= hdr_w[31:0];
            bc_q  <= bc_q + 3'd1;
            if (bc_q == 3'd4) begin
              bc_q   <= '0;
              addr_q <= hdr_w[16 +: ASIZE];
              cnt_q  <= hdr_w[15:0];
              if (hdr_w[15:0] == 16'd0) begin
                txd_q   <= 8'h2E;
                txv_q   <= 1'b1;
                state_q <= ACK;
              end else if (wr_q) begin
                state_q <= WFILL;
              end else begin
                csb_q   <= 1'b0;
                rnw_q   <= 1'b1;
                state_q <= RBUS;
              end
            end
          end else if (to_q == TO_MAX) begin
            txd_q   <= 8'h21;
            txv_q   <= 1'b1;
            state_q <= ERR;
          end else begin
            to_q <= to_q + TW'(1);
          end
        end
        // Little-endian assembly: first byte ends up in dout[7:0].
        WFILL: begin
          if (rx_fire) begin
            to_q   <= '0;
            dout_q <= {rx_data, dout_q[DSIZE-1:8]};
            bc_q   <= bc_q + 3'd1;
            if (bc_q == 3'd3) begin
              bc_q    <= '0;
              csb_q   <= 1'b0;
              rnw_q   <= 1'b0;
              state_q <= WBUS;
            end
          end else if (to_q == TO_MAX) begin
            txd_q   <= 8'h21;
            txv_q   <= 1'b1;
            state_q <= ERR;
          end else begin
            to_q <= to_q + TW'(1);
          end
        end
        WBUS: begin
          if (clken) begin
            csb_q  <= 1'b1;
            rnw_q  <= 1'b1;
            addr_q <= addr_q + ASIZE'(1);
            cnt_q  <= cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
              txd_q   <= 8'h2E;
              txv_q   <= 1'b1;
              state_q <= ACK;
            end else begin
              state_q <= WFILL;
            end
          end
        end
        RBUS: begin
          if (clken) begin
            rd_q    <= din;
            txd_q   <= din[7:0];
            txv_q   <= 1'b1;
            csb_q   <= 1'b1;
            addr_q  <= addr_q + ASIZE'(1);
            cnt_q   <= cnt_q - 16'd1;
            bc_q    <= '0;
            state_q <= RSEND;
          end
        end
        RSEND: begin
          if (tx_fire) begin
            rd_q  <= rd_q >> 8;
            txd_q <= rd_q[15:8];
            bc_q  <= bc_q + 3'd1;
            if (bc_q == 3'd3) begin
              bc_q <= '0;
              if (cnt_q == 16'd0) begin
                txd_q   <= 8'h2E;
                state_q <= ACK;
              end else begin
                txv_q   <= 1'b0;
                csb_q   <= 1'b0;
                rnw_q   <= 1'b1;
                state_q <= RBUS;
              end
            end
          end
        end
        ACK, ERR: begin
          if (tx_fire) begin
            txv_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mem_loader.sv
// Bench for serial_mem_loader: command-level reference model,
// behavioural memory controller and byte sink.
module tb_serial_mem_loader;

  localparam int AS = 20;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          reset_b = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          ext_cs_b;
  logic          rnw;
  logic [AS-1:0] addr;
  logic [31:0]   dout;
  logic [31:0]   din = '0;
  logic          clken = 1'b0;
  logic          busy;

  always #5 clk = ~clk;

  serial_mem_loader #(.ASIZE(AS), .DSIZE(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_b(reset_b),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ext_cs_b(ext_cs_b), .rnw(rnw), .addr(addr), .dout(dout),
    .din(din), .clken(clken), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          rd;
    logic [AS-1:0] a;
    logic [31:0]   d;
    int            cyc;
  } acc_t;

  acc_t        acc_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] mem[logic [AS-1:0]];
  logic [31:0] ref_mem[logic [AS-1:0]];
  logic [31:0] wdata_q[$];

  int lat = 0;
  bit tie_hi = 0;
  int wcnt = 0;
  int cs_cycles = 0;
  int stall_at = -1;
  int stall_len = 0;
  int stall_left = 0;
  int tx_cnt = 0;
  bit rnd_ready = 0;
  bit prev_pend = 0;
  logic [7:0] prev_d = '0;
  int stab_err = 0;
  int overlap_err = 0;

  function automatic logic [31:0] dflt(input logic [AS-1:0] a);
    return {12'h5A5, a} ^ 32'h1357_2468;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory controller: clken after lat wait cycles, or tied high.
  always @(negedge clk) begin
    acc_t e;
    if (!reset_b) begin
      clken = tie_hi;
      wcnt  = 0;
    end else if (ext_cs_b == 1'b0) begin
      cs_cycles++;
      if (tie_hi || wcnt == lat) begin
        clken = 1'b1;
        e.rd  = rnw;
        e.a   = addr;
        e.cyc = wcnt + 1;
        if (rnw) begin
          din = mem.exists(addr) ? mem[addr] : dflt(addr);
          e.d = din;
        end else begin
          mem[addr] = dout;
          e.d = dout;
        end
        acc_q.push_back(e);
      end else begin
        clken = 1'b0;
      end
      wcnt++;
    end else begin
      clken = tie_hi;
      wcnt  = 0;
    end
  end

  // Transmit sink with optional stall and random back-pressure.
  always @(negedge clk) begin
    if (prev_pend && (!tx_valid || tx_data !== prev_d)) stab_err++;
    if (stall_left > 0) begin
      tx_ready = 1'b0;
      stall_left--;
    end else if (tx_cnt == stall_at) begin
      tx_ready = 1'b0;
      stall_left = stall_len - 1;
      stall_at = -1;
    end else begin
      tx_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    if (reset_b && tx_valid && !ext_cs_b) overlap_err++;
    if (reset_b && tx_valid && tx_ready) begin
      tx_q.push_back(tx_data);
      tx_cnt++;
    end
    prev_pend = reset_b && tx_valid && !tx_ready;
    prev_d = tx_data;
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("rx_accept_timeout", 64'(n), 0);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int need);
    int k = 0;
    while ((busy || tx_q.size() < need) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_done_in_time", 64'(k < 5000), 1);
  endtask

  // Reference model: expected bus accesses and tx bytes for one command.
  task automatic run_cmd(input string nm, input bit w,
                         input logic [23:0] a, input logic [15:0] n,
                         input int lt, input bit tie);
    acc_t        ex[$];
    logic [7:0]  et[$];
    acc_t        e;
    logic [31:0] wd;
    lat = lt;
    tie_hi = tie;
    acc_q.delete();
    tx_q.delete();
    tx_cnt = 0;
    send_byte(w ? 8'h57 : 8'h52);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    for (int i = 0; i < int'(n); i++) begin
      e.a = AS'((int'(a[AS-1:0]) + i) % (1 << AS));
      e.rd = !w;
      e.cyc = 1;
      if (w) begin
        wd = (wdata_q.size() > 0) ? wdata_q.pop_front() : $urandom;
        e.d = wd;
        ref_mem[e.a] = wd;
        for (int j = 0; j < 4; j++) send_byte(8'((wd >> (8 * j)) & 32'hFF));
      end else begin
        e.d = ref_mem.exists(e.a) ? ref_mem[e.a] : dflt(e.a);
        for (int j = 0; j < 4; j++) et.push_back(8'((e.d >> (8 * j)) & 32'hFF));
      end
      ex.push_back(e);
    end
    et.push_back(8'h2E);
    wait_idle(et.size());
    chk({nm, "_nacc"}, 64'(acc_q.size()), 64'(ex.size()));
    for (int i = 0; i < ex.size() && i < acc_q.size(); i++) begin
      chk($sformatf("%s_acc%0d", nm, i), {acc_q[i].rd, acc_q[i].a, acc_q[i].d},
          {ex[i].rd, ex[i].a, ex[i].d});
      if (tie) chk($sformatf("%s_cyc%0d", nm, i), 64'(acc_q[i].cyc), 1);
    end
    chk({nm, "_ntx"}, 64'(tx_q.size()), 64'(et.size()));
    for (int i = 0; i < et.size() && i < tx_q.size(); i++)
      chk($sformatf("%s_tx%0d", nm, i), 64'(tx_q[i]), 64'(et[i]));
  endtask

  initial begin
    int c0;
    int k;
    logic [23:0] ra;
    logic [15:0] rn;

    // Reset values
    #12;
    chk("rst_cs_b", 64'(ext_cs_b), 1);
    chk("rst_rnw", 64'(rnw), 1);
    chk("rst_addr", 64'(addr), 0);
    chk("rst_dout", 64'(dout), 0);
    chk("rst_tx_valid", 64'(tx_valid), 0);
    chk("rst_tx_data", 64'(tx_data), 0);
    chk("rst_rx_ready", 64'(rx_ready), 0);
    chk("rst_busy", 64'(busy), 0);
    @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
    chk("idle_rx_ready", 64'(rx_ready), 1);

    // Directed write, two wait states
    wdata_q = '{32'hDEADBEEF, 32'h01020304};
    run_cmd("wr", 1'b1, 24'h000010, 16'd2, 2, 1'b0);

    // Read back with a 10-cycle tx stall mid-stream
    stall_at = 3;
    stall_len = 10;
    run_cmd("rd", 1'b0, 24'h000010, 16'd2, 1, 1'b0);

    // Address wrap and zero count
    run_cmd("wrap", 1'b1, 24'h0FFFFF, 16'd2, 0, 1'b0);
    run_cmd("wrap_rd", 1'b0, 24'h0FFFFF, 16'd2, 3, 1'b0);
    c0 = cs_cycles;
    run_cmd("zero", 1'b1, 24'h000000, 16'd0, 0, 1'b0);
    chk("zero_no_cs", 64'(cs_cycles - c0), 0);

    // Bad command byte
    tx_q.delete();
    send_byte(8'h41);
    wait_idle(1);
    chk("err_code", 64'(tx_q.size() > 0 ? tx_q[0] : 8'h00), 64'h3F);
    chk("err_busy", 64'(busy), 0);

    // Inter-byte timeout inside WFILL
    tx_q.delete();
    acc_q.delete();
    c0 = cs_cycles;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hAA);
    repeat (TO + 20) @(negedge clk);
    chk("to_ntx", 64'(tx_q.size()), 1);
    chk("to_code", 64'(tx_q.size() > 0 ? tx_q[0] : 8'h00), 64'h21);
    chk("to_no_cs", 64'(cs_cycles - c0), 0);
    chk("to_busy", 64'(busy), 0);
    run_cmd("after_to", 1'b0, 24'h000010, 16'd1, 0, 1'b0);

    // Reset during a stalled write access
    lat = 100000;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h20); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    k = 0;
    while (ext_cs_b && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("mid_cs_low", 64'(ext_cs_b), 0);
    repeat (2) @(negedge clk);
    #2 reset_b = 1'b0;
    #1;
    chk("mid_rst_cs_b", 64'(ext_cs_b), 1);
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_tx_valid", 64'(tx_valid), 0);
    @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
    run_cmd("post_rst", 1'b0, 24'h000020, 16'd1, 1, 1'b0);

    // clken tied high: single-clock accesses
    run_cmd("zw_wr", 1'b1, 24'h000300, 16'd3, 0, 1'b1);
    run_cmd("zw_rd", 1'b0, 24'h000300, 16'd3, 0, 1'b1);

    // Randomized write/readback with random back-pressure
    rnd_ready = 1;
    for (int it = 0; it < 5; it++) begin
      ra = {4'($urandom), 20'($urandom)};
      if (it % 2 == 1) ra[19:0] = 20'hFFFFD;
      rn = 16'($urandom_range(0, 4));
      run_cmd($sformatf("rw%0d", it), 1'b1, ra, rn, $urandom_range(0, 3), 1'b0);
      run_cmd($sformatf("rr%0d", it), 1'b0, ra, rn, $urandom_range(0, 3), 1'b0);
    end
    rnd_ready = 0;
    run_cmd("rnd_unwritten", 1'b0, {4'h0, 20'($urandom)}, 16'd2, 1, 1'b0);

    chk("tx_stable", 64'(stab_err), 0);
    chk("cs_high_while_tx", 64'(overlap_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_mem_loader.md
Name: serial_mem_loader

Overview:
- Host-side bus initiator that lets an external PC load and read back external RAM over the serial link without CPU involvement.
- Parses a byte-stream command protocol from a UART receive channel and issues 32-bit word accesses on the same CPU-side port that the memory controller serves (ext_cs_b / rnw / addr / dout / din / clken).
- Returns read data and status bytes on a UART transmit channel.
- Used for boot loading and memory test while the CPU is held in reset.

Parameters:
- ASIZE, 20, word address width on the memory-controller port
- DSIZE, 32, data word width; fixed at 32, 4 bytes per word
- TIMEOUT, 5000000, idle clocks allowed between bytes inside a command before abort

Ports:
- clk  input  1  system clock
- reset_b  input  1  asynchronous active-low reset
- rx_data  input  8  received byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  loader accepts rx_data this cycle
- tx_data  output  8  byte to transmit
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  transmitter accepts tx_data this cycle
- ext_cs_b  output  1  active-low access request to memory controller
- rnw  output  1  1 = read, 0 = write
- addr  output  ASIZE  word address
- dout  output  DSIZE  write data
- din  input  DSIZE  read data from memory controller
- clken  input  1  access-complete strobe from memory controller
- busy  output  1  high whenever state is not IDLE

Behaviour:
- **Reset (async, reset_b low):**
  - State goes to IDLE.
  - ext_cs_b=1, rnw=1, addr=0, dout=0, tx_valid=0, tx_data=0, rx_ready=0, busy=0.
  - Counters and timeout are cleared. An in-flight access is abandoned; ext_cs_b deasserts immediately.
- **Byte handshakes:**
  - Transfer occurs on a rising edge where valid&ready are both 1.
  - tx_data and tx_valid are held stable until accepted.
  - rx_ready is high only in IDLE, HDR and WFILL.
- **Command format:**
  - Byte 0 is the command: 0x57 'W' = write, 0x52 'R' = read.
  - Then A2 A1 A0: 24-bit big-endian word address; the low ASIZE bits are used.
  - Then N1 N0: 16-bit word count. N=0 means zero words; the loader goes directly to ACK.
  - Write data follows as 4 bytes per word, little-endian (first byte goes to dout[7:0]).
- **State machine:**
  - IDLE: rx byte 'W' or 'R' → HDR. Any other byte → ERR, which sends 0x3F '?'.
  - HDR: collects 5 bytes, then:
    - W with N>0 → WFILL
    - R with N>0 → RBUS
    - N=0 → ACK
  - WFILL: assembles 4 bytes into dout, then → WBUS.
  - WBUS: ext_cs_b=0, rnw=0, with addr/dout stable. The access completes on the edge where clken=1. On completion: ext_cs_b=1, addr+1 (wraps 2^ASIZE-1 → 0), count-1. Then → WFILL if count≠0, else → ACK.
  - RBUS: ext_cs_b=0, rnw=1. din is captured on the edge where clken=1; addr+1 (wrapping), count-1; → RSEND.
  - RSEND: sends 4 bytes of the captured word, LSB first. Then → RBUS if count≠0, else → ACK.
  - ACK: sends 0x2E '.' → IDLE.
  - ERR: sends its code → IDLE.
- **Bus timing:**
  - ext_cs_b is asserted for at least one clock.
  - clken sampled while ext_cs_b=1 is ignored.
  - If clken=1 on the first cs cycle, the access completes in 1 clock. There is no combinational path from clken to any output.
- **Timeout:**
  - Applies in HDR and WFILL only.
  - The counter is cleared on each accepted rx byte. When it reaches TIMEOUT, the loader goes to ERR with code 0x21 '!'. Any partial word is discarded and no bus access is issued.
  - The counter does not run during WBUS, RBUS, RSEND or ACK; back-pressure there is unbounded.
- **Bytes arriving at other times:** rx bytes arriving during WBUS/RBUS/RSEND/ACK/ERR are not accepted because rx_ready=0.

Test Plan:
- **Write:** reset, then send 57 00 00 10 00 02 EF BE AD DE 04 03 02 01 with clken pulsed 2 cycles after each ext_cs_b fall → two writes: addr 0x00010 dout 0xDEADBEEF, then addr 0x00011 dout 0x01020304, rnw=0; tx emits 0x2E.
- **Read:** send 52 00 00 10 00 02 with din returning 0xDEADBEEF, then 0x01020304 → tx bytes EF BE AD DE 04 03 02 01 2E; ext_cs_b high during all RSEND cycles; tx_ready stalled 10 cycles mid-stream loses no byte.
- **Address wrap:** W at address 0xFFFFF with N=2 → accesses at 0xFFFFF, then 0x00000. Zero count: 57 00 00 00 00 00 → no ext_cs_b assertion, tx 0x2E.
- **Errors:** rx byte 0x41 in IDLE → tx 0x3F, state returns IDLE. Send 57 00 00 00 00 01 AA then idle TIMEOUT clocks → tx 0x21, no bus access, next command works.
- **Reset mid-access:** assert reset_b low during WBUS with clken held 0 → ext_cs_b=1, busy=0, tx_valid=0 asynchronously; after release, a fresh R command succeeds.
- **Zero-wait:** clken tied high → each word access occupies exactly 1 clock of ext_cs_b=0.
